// File: rtl/mem_fetch_unit_if.sv
// Request/response channels and SRAM-side port of the backing-memory sequencer.
// slave: the sequencer side; master: requester/consumer plus memory model side.
interface mem_fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, mem_cs, mem_we, mem_oe, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, mem_cs, mem_we, mem_oe, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_fetch_unit.sv
// Single-outstanding read/write sequencer driving a synchronous SRAM port for WAIT_STATES+1 cycles.
// Optional saturating response counters are built when MEM_FETCH_STATS_EN is defined.
module mem_fetch_unit #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_fetch_unit_if.slave      bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] stat_rd_cnt,
  output logic [CNT_WIDTH-1:0] stat_wr_cnt
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = CntW'(WAIT_STATES);
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          // Writes echo their own data so the requester sees what landed in memory.
          resp_data_d = we_q ? wdata_q : bus.mem_rdata;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes decode straight from state so they fall with the asynchronous reset.
  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_data  = resp_data_q;
  assign bus.mem_cs     = (state_q == StAccess);
  assign bus.mem_we     = (state_q == StAccess) &&  we_q;
  assign bus.mem_oe     = (state_q == StAccess) && !we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign busy           = (state_q != StIdle);

`ifdef MEM_FETCH_STATS_EN
  logic                 resp_fire;
  logic [CNT_WIDTH-1:0] stat_rd_q, stat_wr_q;

  assign resp_fire = (state_q == StResp) && bus.resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else if (resp_fire) begin
      if (!we_q && (stat_rd_q != '1)) stat_rd_q <= stat_rd_q + 1'b1;
      if ( we_q && (stat_wr_q != '1)) stat_wr_q <= stat_wr_q + 1'b1;
    end
  end

  assign stat_rd_cnt = stat_rd_q;
  assign stat_wr_cnt = stat_wr_q;
`else
  assign stat_rd_cnt = '0;
  assign stat_wr_cnt = '0;
`endif

endmodule
